mem_port_arbiter: RTL

Two-requester round-robin arbiter in front of the 8 x 16-bit dual-port register memory (one write port, one combinational read port). Each requester issues single-word read or write transactions over a valid/ready handshake. The arbiter grants at most one transaction per cycle, drives the memory ports, and returns read data one cycle later. An optional post-reset clear sequencer zero-fills the memory before requests are accepted.

---
 rtl/mem_port_arbiter_pkg.sv | 13 +
 rtl/mem_port_arbiter_if.sv | 27 ++
 rtl/mem_port_arbiter_rr_arb2.sv | 20 ++
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and sizes for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } arb_state_t;

  localparam int MEM_DW = 16;
  localparam int MEM_AW = 3;
  localparam int NREQ   = 2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester-side request/response bundle for the memory port arbiter
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int DW = MEM_DW,
  parameter int AW = MEM_AW
) ();

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rtl/mem_port_arbiter_rr_arb2.sv - combinational two-way round-robin grant
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            last_grant,
  output logic [NREQ-1:0] grant
);

  // lone requester wins; under contention the one not granted last time wins
  always_comb begin
    grant = '0;
    if (req[0] && (!req[1] || last_grant)) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter for the 8x16 register memory; MEM_ARB_CLEAR_EN adds a post-reset zero-fill
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DW = MEM_DW,
  parameter int AW = MEM_AW
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus,
  output logic              clr_busy,
  output logic              mem_we,
  output logic [AW-1:0]     mem_waddr,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_din,
  input  logic [DW-1:0]     mem_dout
);

  logic            last_grant;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] ready;
  logic            run;
  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            sel;
  logic            xfer;
  logic            xfer_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

`ifdef MEM_ARB_CLEAR_EN
  arb_state_t    state;
  arb_state_t    state_next;
  logic [AW-1:0] clr_cnt;
  logic [AW-1:0] clr_cnt_next;

  // state and clear address registers; reset restarts the fill at address 0
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  // one zero write per cycle while clearing, then RUN after the last address
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    clr_we       = 1'b0;
    case (state)
      CLEAR: begin
        clr_we       = reset;
        clr_cnt_next = clr_cnt + 1'b1;
        if (&clr_cnt) begin
          state_next = RUN;
        end
      end
      default: ;
    endcase
  end

  assign clr_addr = clr_cnt;
  assign clr_busy = (state == CLEAR);
  assign run      = (state == RUN);
`else
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
  assign clr_busy = 1'b0;
  assign run      = 1'b1;
`endif

  rr_arb2 u_rr_arb2 (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // requests are only accepted out of reset and outside the clear phase
  assign ready         = (reset && run) ? grant : '0;
  assign bus.req_ready = ready;
  assign sel           = ready[1];
  assign xfer          = |ready;
  assign xfer_we       = xfer && bus.req_we[sel];
  assign sel_addr      = sel ? bus.req_addr[2*AW-1:AW]  : bus.req_addr[AW-1:0];
  assign sel_wdata     = sel ? bus.req_wdata[2*DW-1:DW] : bus.req_wdata[DW-1:0];

  // memory port drive: granted transfer, else clear write, else all zero
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_addr  = '0;
    mem_din   = '0;
    if (xfer_we) begin
      mem_we    = 1'b1;
      mem_waddr = sel_addr;
      mem_din   = sel_wdata;
    end else if (xfer) begin
      mem_addr  = sel_addr;
    end else if (clr_we) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
    end
  end

  // read response capture and round-robin history
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant    <= 1'b1;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= (xfer && !xfer_we) ? ready : '0;
      if (xfer && !xfer_we) begin
        bus.rsp_rdata <= mem_dout;
      end
      if (xfer) begin
        last_grant <= sel;
      end
    end
  end

endmodule
